// File: rtl/mips_regfile_sb.sv
// mips_regfile_sb: pipelined MIPS register file with a post-reset clear sweep,
// write-to-read bypass, and a per-register pending-write scoreboard.
module mips_regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] read_reg_1,
    input  logic [ADDR_W-1:0] read_reg_2,
    output logic [DATA_W-1:0] read_data_1,
    output logic [DATA_W-1:0] read_data_2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              signal_reg_write,
    input  logic [ADDR_W-1:0] reserve_reg,
    input  logic              signal_reserve,
    output logic              busy_1,
    output logic              busy_2,
    output logic              ready
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
    localparam bit HAS_ZERO = (ZERO_REG != 0);

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic              ready_q;
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic run;
    logic wr_ok;
    logic rsv_ok;
    logic byp_1;
    logic byp_2;

    assign run    = (state_q == S_RUN);
    assign wr_ok  = run && signal_reg_write && !(HAS_ZERO && (write_reg == '0));
    assign rsv_ok = run && signal_reserve && !(HAS_ZERO && (reserve_reg == '0));
    assign byp_1  = wr_ok && (write_reg == read_reg_1);
    assign byp_2  = wr_ok && (write_reg == read_reg_2);
    assign ready  = ready_q;

    // Control FSM: reset restarts the clear sweep; the last sweep slot enters RUN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_CLEAR;
            ptr_q   <= '0;
            ready_q <= 1'b0;
            pend_q  <= '0;
        end else begin
            pend_q <= pend_d;
            case (state_q)
                S_CLEAR: begin
                    ptr_q <= ptr_q + 1'b1;
                    if (ptr_q == LAST_PTR) begin
                        state_q <= S_RUN;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_RUN;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Scoreboard next state: release first, then reserve so a new producer wins.
    always_comb begin
        pend_d = pend_q;
        if (run && signal_reg_write) begin
            pend_d[write_reg] = 1'b0;
        end
        if (rsv_ok) begin
            pend_d[reserve_reg] = 1'b1;
        end
        if (HAS_ZERO) begin
            pend_d[0] = 1'b0;
        end
    end

    // Storage: zero fill during the sweep, normal writeback in RUN.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_q == S_CLEAR) begin
                mem_q[ptr_q] <= '0;
            end else if (wr_ok) begin
                mem_q[write_reg] <= write_data;
            end
        end
    end

    // Read port 1: zero register, then bypass, then storage; busy masked by bypass.
    always_comb begin
        read_data_1 = '0;
        busy_1      = 1'b0;
        if (run) begin
            if (HAS_ZERO && (read_reg_1 == '0)) begin
                read_data_1 = '0;
            end else if (byp_1) begin
                read_data_1 = write_data;
            end else begin
                read_data_1 = mem_q[read_reg_1];
            end
            busy_1 = pend_q[read_reg_1] & ~byp_1;
        end
    end

    // Read port 2: same resolution order as port 1.
    always_comb begin
        read_data_2 = '0;
        busy_2      = 1'b0;
        if (run) begin
            if (HAS_ZERO && (read_reg_2 == '0)) begin
                read_data_2 = '0;
            end else if (byp_2) begin
                read_data_2 = write_data;
            end else begin
                read_data_2 = mem_q[read_reg_2];
            end
            busy_2 = pend_q[read_reg_2] & ~byp_2;
        end
    end

endmodule

// File: tb/tb_mips_regfile_sb.sv
// Directed self-checking bench for mips_regfile_sb (DATA_W=32, ADDR_W=5, ZERO_REG=1).
module tb_mips_regfile_sb;

    logic        clk;
    logic        rst_n;
    logic [4:0]  read_reg_1;
    logic [4:0]  read_reg_2;
    logic [31:0] read_data_1;
    logic [31:0] read_data_2;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        signal_reg_write;
    logic [4:0]  reserve_reg;
    logic        signal_reserve;
    logic        busy_1;
    logic        busy_2;
    logic        ready;

    int n_vec;
    int n_err;

    mips_regfile_sb #(
        .DATA_W  (32),
        .ADDR_W  (5),
        .ZERO_REG(1)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .read_reg_1      (read_reg_1),
        .read_reg_2      (read_reg_2),
        .read_data_1     (read_data_1),
        .read_data_2     (read_data_2),
        .write_reg       (write_reg),
        .write_data      (write_data),
        .signal_reg_write(signal_reg_write),
        .reserve_reg     (reserve_reg),
        .signal_reserve  (signal_reserve),
        .busy_1          (busy_1),
        .busy_2          (busy_2),
        .ready           (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        signal_reg_write = 1'b0;
        signal_reserve   = 1'b0;
        write_reg        = '0;
        write_data       = '0;
        reserve_reg      = '0;
    endtask

    // Counts posedges after release until ready is seen; 100 means it never rose.
    task automatic wait_ready(output int n);
        n = 100;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (ready) begin
                n = i + 1;
                break;
            end
        end
    endtask

    int n;

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        read_reg_1 = 5'd1;
        read_reg_2 = 5'd2;
        idle();
        tick();
        tick();
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_busy1", 32'(busy_1), 32'd0);
        chk("rst_rd1", read_data_1, 32'd0);

        // Initial clear sweep
        rst_n = 1'b1;
        wait_ready(n);
        chk("clr_lat_initial", 32'(n), 32'd32);

        // Preload reg 7 with garbage; bypass visible same cycle
        read_reg_1 = 5'd7;
        signal_reg_write = 1'b1; write_reg = 5'd7; write_data = 32'hBAD0_0007;
        #1;
        chk("pre7_byp", read_data_1, 32'hBAD0_0007);
        tick();
        idle();
        #1;
        chk("pre7_mem", read_data_1, 32'hBAD0_0007);

        // Reset pulse, with writes to 7 and a reserve of 3 held through the sweep
        read_reg_2 = 5'd3;
        rst_n = 1'b0;
        signal_reg_write = 1'b1; write_reg = 5'd7; write_data = 32'h0000_0077;
        signal_reserve = 1'b1; reserve_reg = 5'd3;
        tick();
        chk("pulse_ready", 32'(ready), 32'd0);
        rst_n = 1'b1;
        n = 100;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (i == 19) begin
                chk("clr_rd1", read_data_1, 32'd0);
                chk("clr_busy2", 32'(busy_2), 32'd0);
            end
            if (ready) begin
                n = i + 1;
                break;
            end
        end
        idle();
        #1;
        chk("clr_lat_pulse", 32'(n), 32'd32);
        chk("clr7_zero", read_data_1, 32'd0);
        chk("clr_rsv3_busy", 32'(busy_2), 32'd0);

        // Write 5 with bypass, then from storage
        read_reg_1 = 5'd5;
        signal_reg_write = 1'b1; write_reg = 5'd5; write_data = 32'hDEAD_BEEF;
        #1;
        chk("w5_byp", read_data_1, 32'hDEAD_BEEF);
        tick();
        idle();
        #1;
        chk("w5_mem", read_data_1, 32'hDEAD_BEEF);

        // Register 0: writes and reserves are dropped
        read_reg_2 = 5'd0;
        signal_reg_write = 1'b1; write_reg = 5'd0; write_data = 32'h1234_5678;
        signal_reserve = 1'b1; reserve_reg = 5'd0;
        #1;
        chk("r0_byp", read_data_2, 32'd0);
        chk("r0_busy_same", 32'(busy_2), 32'd0);
        tick();
        idle();
        #1;
        chk("r0_mem", read_data_2, 32'd0);
        chk("r0_busy_after", 32'(busy_2), 32'd0);

        // Reserve 9: busy only from the next cycle
        read_reg_1 = 5'd9;
        signal_reserve = 1'b1; reserve_reg = 5'd9;
        #1;
        chk("rsv9_same", 32'(busy_1), 32'd0);
        tick();
        idle();
        #1;
        chk("rsv9_busy_a", 32'(busy_1), 32'd1);
        tick();
        chk("rsv9_busy_b", 32'(busy_1), 32'd1);
        // Release write to 9
        signal_reg_write = 1'b1; write_reg = 5'd9; write_data = 32'hCAFE_0009;
        #1;
        chk("rel9_busy", 32'(busy_1), 32'd0);
        chk("rel9_byp", read_data_1, 32'hCAFE_0009);
        tick();
        idle();
        #1;
        chk("rel9_busy_after", 32'(busy_1), 32'd0);
        chk("rel9_mem", read_data_1, 32'hCAFE_0009);

        // Pending 9, then same-cycle reserve and write: set wins
        signal_reserve = 1'b1; reserve_reg = 5'd9;
        tick();
        idle();
        signal_reserve = 1'b1; reserve_reg = 5'd9;
        signal_reg_write = 1'b1; write_reg = 5'd9; write_data = 32'hA5A5_A5A5;
        #1;
        chk("both9_byp", read_data_1, 32'hA5A5_A5A5);
        chk("both9_busy_same", 32'(busy_1), 32'd0);
        tick();
        idle();
        #1;
        chk("both9_busy_next", 32'(busy_1), 32'd1);
        chk("both9_mem", read_data_1, 32'hA5A5_A5A5);
        signal_reg_write = 1'b1; write_reg = 5'd9; write_data = 32'h0000_0001;
        tick();
        idle();
        #1;
        chk("both9_released", 32'(busy_1), 32'd0);

        // Write to a non-pending register leaves pend at 0
        read_reg_2 = 5'd12;
        signal_reg_write = 1'b1; write_reg = 5'd12; write_data = 32'h0000_000C;
        tick();
        idle();
        #1;
        chk("w12_busy", 32'(busy_2), 32'd0);
        chk("w12_mem", read_data_2, 32'h0000_000C);

        // Reset in the middle of the sweep (ptr=10) restarts from 0
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("mid_ready_lo", 32'(ready), 32'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        wait_ready(n);
        chk("clr_lat_mid", 32'(n), 32'd32);
        read_reg_1 = 5'd5;
        #1;
        chk("mid_r5_zero", read_data_1, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
